// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - GPIO register map and APB sequencer enums
package gpio_pkg;

    localparam logic [7:0] GPIO_MODE      = 8'h00;
    localparam logic [7:0] GPIO_DIRECTION = 8'h04;
    localparam logic [7:0] GPIO_OUTPUT    = 8'h08;
    localparam logic [7:0] GPIO_INPUT     = 8'h0C;
    localparam logic [7:0] GPIO_TR_TYPE   = 8'h10;
    localparam logic [7:0] GPIO_TR_LVL0   = 8'h14;
    localparam logic [7:0] GPIO_TR_LVL1   = 8'h18;
    localparam logic [7:0] GPIO_TR_STAT   = 8'h1C;
    localparam logic [7:0] GPIO_IRQ_ENA   = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } apb_state_t;

    typedef enum logic [1:0] {
        SRC_HOST,
        SRC_IRQ_RD,
        SRC_IRQ_CLR
    } xfer_src_t;

endpackage

// File: rtl/apb_gpio_ctrl.sv
// rtl/apb_gpio_ctrl.sv - APB master arbitrating host commands and GPIO interrupt service
module apb_gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int PADDR_SIZE  = 32,
    parameter int PDATA_SIZE  = 32,
    parameter int IRQ_HOLDOFF = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [PADDR_SIZE-1:0]   cmd_addr,
    input  logic [PDATA_SIZE-1:0]   cmd_wdata,
    input  logic [PDATA_SIZE/8-1:0] cmd_strb,

    output logic                    rsp_valid,
    output logic [PDATA_SIZE-1:0]   rsp_rdata,
    output logic                    rsp_err,

    input  logic                    irq_i,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [PDATA_SIZE-1:0]   evt_status,

    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [PADDR_SIZE-1:0]   PADDR,
    output logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PDATA_SIZE-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int STRB_W = PDATA_SIZE / 8;
    localparam int HO_W   = $clog2(IRQ_HOLDOFF + 1);
    localparam logic [HO_W-1:0]       HO_LOAD      = HO_W'(IRQ_HOLDOFF);
    localparam logic [PADDR_SIZE-1:0] TR_STAT_ADDR = PADDR_SIZE'(GPIO_TR_STAT);

    apb_state_t              state, state_nxt;
    xfer_src_t               src, src_nxt;
    logic                    psel_nxt, penable_nxt, pwrite_nxt;
    logic [PADDR_SIZE-1:0]   paddr_nxt;
    logic [PDATA_SIZE-1:0]   pwdata_nxt;
    logic [STRB_W-1:0]       pstrb_nxt;

    logic [HO_W-1:0]         holdoff;
    logic                    clr_pending;
    logic [PDATA_SIZE-1:0]   stat_lat;
    logic                    irq_elig;
    logic                    xfer_done;

    assign irq_elig  = irq_i && (holdoff == '0) && !evt_valid;
    assign xfer_done = (state == ST_ACCESS) && PREADY;
    // A pending clear write must follow its status read before the host gets the bus.
    assign cmd_ready = PRESETn && (state == ST_IDLE) && !clr_pending && !irq_elig;

    always_comb begin
        state_nxt   = state;
        src_nxt     = src;
        psel_nxt    = PSEL;
        penable_nxt = PENABLE;
        pwrite_nxt  = PWRITE;
        paddr_nxt   = PADDR;
        pwdata_nxt  = PWDATA;
        pstrb_nxt   = PSTRB;
        case (state)
            ST_IDLE: begin
                if (clr_pending) begin
                    state_nxt  = ST_SETUP;
                    src_nxt    = SRC_IRQ_CLR;
                    psel_nxt   = 1'b1;
                    pwrite_nxt = 1'b1;
                    paddr_nxt  = TR_STAT_ADDR;
                    pwdata_nxt = stat_lat;
                    pstrb_nxt  = '1;
                end else if (irq_elig) begin
                    state_nxt  = ST_SETUP;
                    src_nxt    = SRC_IRQ_RD;
                    psel_nxt   = 1'b1;
                    pwrite_nxt = 1'b0;
                    paddr_nxt  = TR_STAT_ADDR;
                    pwdata_nxt = '0;
                    pstrb_nxt  = '0;
                end else if (cmd_valid) begin
                    state_nxt  = ST_SETUP;
                    src_nxt    = SRC_HOST;
                    psel_nxt   = 1'b1;
                    pwrite_nxt = cmd_write;
                    paddr_nxt  = cmd_addr;
                    pwdata_nxt = cmd_write ? cmd_wdata : '0;
                    pstrb_nxt  = cmd_write ? cmd_strb : '0;
                end
            end
            ST_SETUP: begin
                state_nxt   = ST_ACCESS;
                penable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_nxt   = ST_IDLE;
                    psel_nxt    = 1'b0;
                    penable_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= ST_IDLE;
            src     <= SRC_HOST;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            PSTRB   <= '0;
        end else begin
            state   <= state_nxt;
            src     <= src_nxt;
            PSEL    <= psel_nxt;
            PENABLE <= penable_nxt;
            PWRITE  <= pwrite_nxt;
            PADDR   <= paddr_nxt;
            PWDATA  <= pwdata_nxt;
            PSTRB   <= pstrb_nxt;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            evt_valid   <= 1'b0;
            evt_status  <= '0;
            holdoff     <= '0;
            clr_pending <= 1'b0;
            stat_lat    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (holdoff != '0)
                holdoff <= holdoff - HO_W'(1);
            if (evt_valid && evt_ready)
                evt_valid <= 1'b0;
            if ((state == ST_IDLE) && clr_pending)
                clr_pending <= 1'b0;
            if (xfer_done) begin
                case (src)
                    SRC_HOST: begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR;
                    end
                    SRC_IRQ_RD: begin
                        if ((PRDATA != '0) && !PSLVERR) begin
                            stat_lat    <= PRDATA;
                            clr_pending <= 1'b1;
                        end else begin
                            holdoff <= HO_LOAD;
                        end
                    end
                    default: begin
                        // Holdoff masks the stale irq_i while the peripheral's registered irq_o falls.
                        holdoff <= HO_LOAD;
                        if (!PSLVERR) begin
                            evt_valid  <= 1'b1;
                            evt_status <= stat_lat;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
// tb/tb_apb_gpio_ctrl.sv - self-checking bench for apb_gpio_ctrl with a behavioural GPIO slave
module tb_apb_gpio_ctrl;
    import gpio_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int HOLD = 2;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          irq_i;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [DW-1:0] evt_status;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [DW-1:0] PRDATA;
    logic          PREADY, PSLVERR;

    int errors = 0;
    int checks = 0;

    apb_gpio_ctrl #(.PADDR_SIZE(AW), .PDATA_SIZE(DW), .IRQ_HOLDOFF(HOLD)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .irq_i(irq_i), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_status(evt_status),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // GPIO slave: plain registers, W1C trigger status, registered irq output
    logic [DW-1:0] regs [0:15] = '{default: '0};
    logic [DW-1:0] edge_set = '0;
    logic [DW-1:0] level_bits = '0;
    logic [DW-1:0] tr;
    logic          irq_reg = 1'b0;
    logic          irq_force = 1'b0;
    logic          err_req = 1'b0;
    int            stall_req = 0;
    int            wait_cnt = 0;
    int            cyc = 0;
    logic [3:0]    ridx;

    assign ridx    = PADDR[5:2];
    assign PRDATA  = (PSEL && PENABLE) ? regs[ridx] : '0;
    assign PREADY  = !(PSEL && PENABLE) || (wait_cnt >= stall_req);
    assign PSLVERR = PSEL && PENABLE && PREADY && err_req;
    assign irq_i   = irq_reg | irq_force;

    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        wait_cnt <= (PSEL && PENABLE && !PREADY) ? wait_cnt + 1 : 0;
        tr = regs[7] | edge_set | level_bits;
        if (PSEL && PENABLE && PREADY && PWRITE && !err_req) begin
            if (ridx == 4'd7)
                tr = tr & ~PWDATA;
            else
                for (int b = 0; b < SW; b++)
                    if (PSTRB[b]) regs[ridx][8*b +: 8] <= PWDATA[8*b +: 8];
        end
        regs[7] <= tr;
        irq_reg <= |(regs[7] & regs[8]);
    end

    typedef struct packed {
        int            c;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } xfer_t;

    xfer_t         xq[$];
    xfer_t         xe;
    int            rsp_cnt = 0;
    int            stab_err = 0;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_data = '0;
    logic [SW-1:0] s_strb = '0;
    logic          s_w = 1'b0;

    always @(negedge PCLK) begin
        if (PSEL && !PENABLE) begin
            s_addr = PADDR; s_data = PWDATA; s_strb = PSTRB; s_w = PWRITE;
        end
        if (PSEL && PENABLE) begin
            if ({PADDR, PWDATA, PSTRB, PWRITE} !== {s_addr, s_data, s_strb, s_w})
                stab_err++;
            if (PREADY) begin
                xe.c = cyc; xe.w = PWRITE; xe.a = PADDR; xe.d = PWDATA; xe.s = PSTRB;
                xq.push_back(xe);
            end
        end
        if (rsp_valid) rsp_cnt++;
    end

    // Reference register contents as seen by the host
    logic [DW-1:0] mem_exp [0:15] = '{default: '0};

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic host_xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, output logic [DW-1:0] rd, output logic er);
        int n;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
        n = 0;
        while (!cmd_ready && n < 60) begin @(negedge PCLK); n++; end
        @(negedge PCLK);
        cmd_valid = 1'b0;
        while (!rsp_valid && n < 120) begin @(negedge PCLK); n++; end
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL host_timeout: addr %h no rsp_valid, required rsp_valid=1", a);
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge PCLK);
    endtask

    task automatic wait_evt(output int t);
        int n;
        n = 0;
        while (!evt_valid && n < 60) begin @(negedge PCLK); n++; end
        t = cyc;
        checks++;
        if (!evt_valid) begin
            errors++;
            $display("FAIL evt_timeout: evt_valid=%0d, required 1", evt_valid);
        end
    endtask

    task automatic consume_evt();
        evt_ready = 1'b1;
        @(negedge PCLK);
        evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid, rsp_err, evt_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b, required 0000000",
                     {PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid, rsp_err, evt_valid});
        end
        checks++;
        if ({PADDR, PWDATA, PSTRB, rsp_rdata, evt_status} !== '0) begin
            errors++;
            $display("FAIL reset_data: paddr %h pwdata %h pstrb %h rdata %h evt %h, required all 0",
                     PADDR, PWDATA, PSTRB, rsp_rdata, evt_status);
        end
        PRESETn = 1'b1;
        @(negedge PCLK);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: cmd_ready=%0d, required 1", cmd_ready);
        end
    endtask

    task automatic test_host_write();
        logic [DW-1:0] rd;
        logic er;
        int n;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = AW'(GPIO_DIRECTION);
        cmd_wdata = 32'h0000_00FF; cmd_strb = 4'hF;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge PCLK); n++; end
        @(negedge PCLK);
        cmd_valid = 1'b0;
        checks++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 32'h4 || PWDATA !== 32'hFF || PSTRB !== 4'hF) begin
            errors++;
            $display("FAIL wr_setup: psel/pen/pwr %b addr %h data %h strb %h, required 101 4 ff f",
                     {PSEL, PENABLE, PWRITE}, PADDR, PWDATA, PSTRB);
        end
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            errors++;
            $display("FAIL wr_access: psel/penable %b, required 11", {PSEL, PENABLE});
        end
        @(negedge PCLK);
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== '0) begin
            errors++;
            $display("FAIL wr_rsp: valid/err %b rdata %h, required 10 00000000", {rsp_valid, rsp_err}, rsp_rdata);
        end
        @(negedge PCLK);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_rsp_pulse: rsp_valid=%0d, required 0", rsp_valid);
        end
        mem_exp[1] = merge(mem_exp[1], 32'hFF, 4'hF);
        host_xfer(1'b0, AW'(GPIO_DIRECTION), '0, '0, rd, er);
        checks++;
        if (rd !== 32'h0000_00FF || er !== 1'b0) begin
            errors++;
            $display("FAIL rd_back: got %h err %0d, required 000000ff err 0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d1, d2, rd;
        logic er;
        int n, c1, c2;
        d1 = $urandom; d2 = $urandom;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = AW'(GPIO_MODE); cmd_wdata = d1; cmd_strb = 4'hF;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge PCLK); n++; end
        c1 = cyc;
        @(negedge PCLK);
        cmd_addr = AW'(GPIO_TR_LVL0); cmd_wdata = d2;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge PCLK); n++; end
        c2 = cyc;
        checks++;
        if (c2 - c1 != 3 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rate: spacing %0d rsp_valid %0d, required 3 and 1", c2 - c1, rsp_valid);
        end
        @(negedge PCLK);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge PCLK); n++; end
        @(negedge PCLK);
        mem_exp[0] = d1;
        mem_exp[5] = d2;
        host_xfer(1'b0, AW'(GPIO_MODE), '0, '0, rd, er);
        checks++;
        if (rd !== mem_exp[0]) begin
            errors++;
            $display("FAIL b2b_rd0: got %h, required %h", rd, mem_exp[0]);
        end
        host_xfer(1'b0, AW'(GPIO_TR_LVL0), '0, '0, rd, er);
        checks++;
        if (rd !== mem_exp[5]) begin
            errors++;
            $display("FAIL b2b_rd5: got %h, required %h", rd, mem_exp[5]);
        end
    endtask

    task automatic test_stall();
        int n, acc, s0;
        stall_req = 3;
        s0 = stab_err;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(GPIO_DIRECTION); cmd_strb = '0;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge PCLK); n++; end
        @(negedge PCLK);
        cmd_valid = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE) acc++;
            else if (acc > 0) break;
        end
        checks++;
        if (acc != 4) begin
            errors++;
            $display("FAIL stall_len: access cycles %0d, required 4", acc);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== mem_exp[1]) begin
            errors++;
            $display("FAIL stall_rsp: valid %0d rdata %h, required 1 %h", rsp_valid, rsp_rdata, mem_exp[1]);
        end
        checks++;
        if (stab_err != s0) begin
            errors++;
            $display("FAIL stall_stable: %0d unstable access cycles, required 0", stab_err - s0);
        end
        stall_req = 0;
        @(negedge PCLK);
    endtask

    task automatic test_irq_service();
        logic [DW-1:0] rd, bits;
        logic er;
        int n, n0, r0, t0, t1;
        host_xfer(1'b1, AW'(GPIO_IRQ_ENA), 32'hFFFF_FFFF, 4'hF, rd, er);
        mem_exp[8] = 32'hFFFF_FFFF;
        n0 = xq.size();
        r0 = rsp_cnt;
        edge_set = 32'h8;
        @(negedge PCLK);
        edge_set = '0;
        n = 0;
        while (!irq_i && n < 10) begin @(negedge PCLK); n++; end
        t0 = cyc;
        wait_evt(t1);
        checks++;
        if (t1 - t0 != 6 || evt_status !== 32'h8) begin
            errors++;
            $display("FAIL irq_evt: latency %0d status %h, required 6 00000008", t1 - t0, evt_status);
        end
        checks++;
        if (xq.size() - n0 != 2) begin
            errors++;
            $display("FAIL irq_xfers: %0d transfers, required 2", xq.size() - n0);
        end else begin
            checks++;
            if (xq[n0].w !== 1'b0 || xq[n0].a !== AW'(GPIO_TR_STAT) || xq[n0+1].w !== 1'b1 ||
                xq[n0+1].a !== AW'(GPIO_TR_STAT) || xq[n0+1].d !== 32'h8 || xq[n0+1].s !== 4'hF) begin
                errors++;
                $display("FAIL irq_seq: rd w%0d a%h, clr w%0d a%h d%h s%h, required 0 1c / 1 1c 8 f",
                         xq[n0].w, xq[n0].a, xq[n0+1].w, xq[n0+1].a, xq[n0+1].d, xq[n0+1].s);
            end
        end
        consume_evt();
        repeat (20) @(negedge PCLK);
        checks++;
        if (xq.size() - n0 != 2 || irq_i !== 1'b0 || evt_valid !== 1'b0 || rsp_cnt != r0) begin
            errors++;
            $display("FAIL irq_once: xfers %0d irq %0d evt %0d rsp %0d, required 2 0 0 0",
                     xq.size() - n0, irq_i, evt_valid, rsp_cnt - r0);
        end
        for (int k = 0; k < 4; k++) begin
            bits = $urandom | 32'h1;
            edge_set = bits;
            @(negedge PCLK);
            edge_set = '0;
            wait_evt(t1);
            checks++;
            if (evt_status !== bits) begin
                errors++;
                $display("FAIL irq_rand: status %h, required %h", evt_status, bits);
            end
            consume_evt();
        end
        repeat (4) @(negedge PCLK);
        host_xfer(1'b0, AW'(GPIO_TR_STAT), '0, '0, rd, er);
        checks++;
        if (rd !== '0) begin
            errors++;
            $display("FAIL irq_cleared: tr_stat %h, required 00000000", rd);
        end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] rd;
        logic er;
        int n, n0, r0, t1;
        edge_set = 32'h4;
        @(negedge PCLK);
        edge_set = '0;
        n = 0;
        while (!irq_i && n < 10) begin @(negedge PCLK); n++; end
        n0 = xq.size();
        r0 = rsp_cnt;
        host_xfer(1'b0, AW'(GPIO_DIRECTION), '0, '0, rd, er);
        checks++;
        if (xq.size() - n0 != 3) begin
            errors++;
            $display("FAIL sim_count: %0d transfers, required 3", xq.size() - n0);
        end else begin
            checks++;
            if (xq[n0].w !== 1'b0 || xq[n0].a !== AW'(GPIO_TR_STAT) || xq[n0+1].w !== 1'b1 ||
                xq[n0+1].a !== AW'(GPIO_TR_STAT) || xq[n0+2].a !== AW'(GPIO_DIRECTION) ||
                xq[n0+2].c - xq[n0+1].c != 3) begin
                errors++;
                $display("FAIL sim_order: addrs %h %h %h gap %0d, required 1c 1c 04 gap 3",
                         xq[n0].a, xq[n0+1].a, xq[n0+2].a, xq[n0+2].c - xq[n0+1].c);
            end
        end
        checks++;
        if (rd !== mem_exp[1] || rsp_cnt - r0 != 1) begin
            errors++;
            $display("FAIL sim_rsp: rdata %h responses %0d, required %h 1", rd, rsp_cnt - r0, mem_exp[1]);
        end
        wait_evt(t1);
        checks++;
        if (evt_status !== 32'h4) begin
            errors++;
            $display("FAIL sim_evt: status %h, required 00000004", evt_status);
        end
        consume_evt();
        repeat (4) @(negedge PCLK);
    endtask

    task automatic test_evt_backpressure();
        logic [DW-1:0] rd, d;
        logic er;
        int n0, n1, irq_new, t1;
        logic found;
        level_bits = 32'h10;
        wait_evt(t1);
        checks++;
        if (evt_status !== 32'h10) begin
            errors++;
            $display("FAIL bp_evt: status %h, required 00000010", evt_status);
        end
        n0 = xq.size();
        d = $urandom;
        host_xfer(1'b1, AW'(GPIO_OUTPUT), d, 4'hF, rd, er);
        mem_exp[2] = d;
        host_xfer(1'b0, AW'(GPIO_OUTPUT), '0, '0, rd, er);
        checks++;
        if (rd !== mem_exp[2]) begin
            errors++;
            $display("FAIL bp_host: rdata %h, required %h", rd, mem_exp[2]);
        end
        repeat (10) @(negedge PCLK);
        irq_new = 0;
        for (int i = n0; i < xq.size(); i++)
            if (xq[i].a == AW'(GPIO_TR_STAT)) irq_new++;
        checks++;
        if (irq_new != 0 || xq.size() - n0 != 2 || evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_block: irq xfers %0d total %0d evt %0d, required 0 2 1",
                     irq_new, xq.size() - n0, evt_valid);
        end
        n1 = xq.size();
        consume_evt();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge PCLK);
            for (int j = n1; j < xq.size(); j++)
                if (xq[j].a == AW'(GPIO_TR_STAT) && !xq[j].w) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bp_resume: irq read after evt_ready %0d, required 1", found);
        end
        level_bits = '0;
        evt_ready = 1'b1;
        repeat (40) @(negedge PCLK);
        evt_ready = 1'b0;
    endtask

    task automatic test_zero_read();
        int n, n0;
        n0 = xq.size();
        irq_force = 1'b1;
        n = 0;
        while (xq.size() - n0 < 2 && n < 40) begin @(negedge PCLK); n++; end
        irq_force = 1'b0;
        repeat (10) @(negedge PCLK);
        checks++;
        if (xq.size() - n0 < 2) begin
            errors++;
            $display("FAIL zero_count: %0d transfers, required at least 2", xq.size() - n0);
        end else begin
            checks++;
            if (xq[n0].w !== 1'b0 || xq[n0+1].w !== 1'b0 || xq[n0+1].a !== AW'(GPIO_TR_STAT) ||
                xq[n0+1].c - xq[n0].c != HOLD + 3) begin
                errors++;
                $display("FAIL zero_seq: w %0d %0d gap %0d, required 0 0 gap %0d",
                         xq[n0].w, xq[n0+1].w, xq[n0+1].c - xq[n0].c, HOLD + 3);
            end
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_evt: evt_valid %0d, required 0", evt_valid);
        end
    endtask

    task automatic test_random_host();
        logic [DW-1:0] rd, d, exp_rd;
        logic [SW-1:0] s;
        logic er, w, e;
        int idx;
        for (int k = 0; k < 12; k++) begin
            idx = $urandom_range(0, 5);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            s = SW'($urandom);
            e = ($urandom_range(0, 3) == 0);
            err_req = e;
            stall_req = $urandom_range(0, 2);
            exp_rd = w ? '0 : mem_exp[idx];
            host_xfer(w, AW'(idx * 4), d, s, rd, er);
            if (w && !e) mem_exp[idx] = merge(mem_exp[idx], d, s);
            checks++;
            if (rd !== exp_rd || er !== e) begin
                errors++;
                $display("FAIL rand_host: idx %0d w %0d rdata %h err %0d, required %h err %0d",
                         idx, w, rd, er, exp_rd, e);
            end
        end
        err_req = 1'b0;
        stall_req = 0;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] rd, d;
        logic er;
        int n, r0;
        stall_req = 6;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(GPIO_DIRECTION); cmd_strb = '0;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge PCLK); n++; end
        @(negedge PCLK);
        cmd_valid = 1'b0;
        n = 0;
        while (!(PSEL && PENABLE) && n < 10) begin @(negedge PCLK); n++; end
        r0 = rsp_cnt;
        PRESETn = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, cmd_ready} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid: psel/penable/ready %b, required 000", {PSEL, PENABLE, cmd_ready});
        end
        repeat (2) @(negedge PCLK);
        stall_req = 0;
        PRESETn = 1'b1;
        @(negedge PCLK);
        checks++;
        if (rsp_cnt != r0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_after: responses %0d ready %0d, required 0 1", rsp_cnt - r0, cmd_ready);
        end
        d = $urandom;
        host_xfer(1'b1, AW'(GPIO_TR_TYPE), d, 4'hF, rd, er);
        mem_exp[4] = d;
        host_xfer(1'b0, AW'(GPIO_TR_TYPE), '0, '0, rd, er);
        checks++;
        if (rd !== mem_exp[4] || rsp_cnt - r0 != 2) begin
            errors++;
            $display("FAIL rst_resume: rdata %h responses %0d, required %h 2", rd, rsp_cnt - r0, mem_exp[4]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_host_write();
        test_back_to_back();
        test_stall();
        test_irq_service();
        test_simultaneous();
        test_evt_backpressure();
        test_zero_read();
        test_random_host();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
